mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq_pkg.sv | 14 +
 rtl/mul_seq.sv | 138 +++++++++++++
 tb/tb_mul_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and default sizing for the sequential shift-add multiplier.
package mul_seq_pkg;

   localparam int unsigned W_DEF = 8;
   localparam int unsigned D_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      WR_LO = 2'd2,
      WR_HI = 2'd3
   } state_t;

endpackage : mul_seq_pkg

// File: rtl/mul_seq.sv
// Sequential unsigned W x W multiplier (one multiplier bit per cycle, LSB
// first) that writes the 2W-bit product back to a register file as two words.
module mul_seq
   import mul_seq_pkg::*;
#(
   parameter int unsigned W = W_DEF,
   parameter int unsigned D = D_DEF
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [W-1:0] OpA,
   input  logic [W-1:0] OpB,
   input  logic [D-1:0] DestAddr,
   output logic         Busy,
   output logic         Done,
   output logic         WrEn,
   output logic [D-1:0] WrAddr,
   output logic [W-1:0] WrData
);

   localparam int unsigned CW = $clog2(W) + 1;
   localparam int unsigned PW = 2 * W;

   state_t          state_q, state_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [PW-1:0]   mcand_q, mcand_d;
   logic [W-1:0]    mplier_q, mplier_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [D-1:0]    dest_q, dest_d;

   logic            busy_d, done_d, wr_en_d;
   logic [D-1:0]    wr_addr_d;
   logic [W-1:0]    wr_data_d;

   logic            last_bit;

   assign last_bit = (cnt_q == CW'(W - 1));

   // State and datapath registers; reset aborts any operation in progress.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         dest_q   <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         dest_q   <= dest_d;
      end
   end

   // Next-state logic: fixed W-cycle CALC, then two write cycles.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (Start) state_d = CALC;
         CALC:    if (last_bit) state_d = WR_LO;
         WR_LO:   state_d = WR_HI;
         WR_HI:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: operands latched on accept, shift-add in CALC.
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      dest_d   = dest_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               acc_d    = '0;
               mcand_d  = PW'(OpA);
               mplier_d = OpB;
               cnt_d    = '0;
               dest_d   = DestAddr;
            end
         end
         CALC: begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
         end
         default: ;
      endcase
   end

   // Output decode from the upcoming state so outputs leave a register.
   always_comb begin
      busy_d    = (state_d != IDLE);
      done_d    = 1'b0;
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;
      case (state_d)
         WR_LO: begin
            wr_en_d   = 1'b1;
            wr_addr_d = dest_q;
            wr_data_d = acc_d[W-1:0];
         end
         WR_HI: begin
            wr_en_d   = 1'b1;
            done_d    = 1'b1;
            wr_addr_d = dest_q + D'(1);
            wr_data_d = acc_d[PW-1:W];
         end
         default: ;
      endcase
   end

   // Output registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Busy   <= 1'b0;
         Done   <= 1'b0;
         WrEn   <= 1'b0;
         WrAddr <= '0;
         WrData <= '0;
      end else begin
         Busy   <= busy_d;
         Done   <= done_d;
         WrEn   <= wr_en_d;
         WrAddr <= wr_addr_d;
         WrData <= wr_data_d;
      end
   end

endmodule : mul_seq

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: the driver queues expected writes, a monitor
// checks every write-back cycle against the queue.
module tb_mul_seq;

   logic       Clk;
   logic       Reset;
   logic       Start;
   logic [7:0] OpA;
   logic [7:0] OpB;
   logic [3:0] DestAddr;
   logic       Busy;
   logic       Done;
   logic       WrEn;
   logic [3:0] WrAddr;
   logic [7:0] WrData;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
      logic       done;
   } exp_t;

   exp_t sb[$];
   int   assertions = 0;
   int   failures   = 0;
   int   wr_cnt     = 0;

   mul_seq #(.W(8), .D(4)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (Start),
      .OpA      (OpA),
      .OpB      (OpB),
      .DestAddr (DestAddr),
      .Busy     (Busy),
      .Done     (Done),
      .WrEn     (WrEn),
      .WrAddr   (WrAddr),
      .WrData   (WrData)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic void check(input string name, input int act, input int exp);
      assertions++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: every write cycle must match the head of the scoreboard.
   always @(negedge Clk) begin
      if (!Reset) begin
         if (WrEn) begin
            wr_cnt++;
            if (sb.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("wr_addr", int'(WrAddr), int'(e.addr));
               check("wr_data", int'(WrData), int'(e.data));
               check("wr_done", int'(Done), int'(e.done));
            end
         end else begin
            check("idle_done", int'(Done), 0);
            check("idle_wrdata", int'(WrData), 0);
            check("idle_wraddr", int'(WrAddr), 0);
         end
      end
   end

   // Issue one multiply, optionally pulsing Start at edges p1/p2 of the op.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] dst,
                         input logic [3:0] lo_a, input logic [7:0] lo_d,
                         input logic [3:0] hi_a, input logic [7:0] hi_d,
                         input int p1, input int p2);
      int guard;
      int busy_cnt;
      int done_at;
      int wr_before;
      exp_t e;
      guard = 0;
      while (Busy && guard < 50) begin
         @(negedge Clk);
         guard++;
      end
      check("idle_wait_timeout", int'(guard < 50), 1);
      Start    = 1'b1;
      OpA      = a;
      OpB      = b;
      DestAddr = dst;
      e.addr = lo_a; e.data = lo_d; e.done = 1'b0; sb.push_back(e);
      e.addr = hi_a; e.data = hi_d; e.done = 1'b1; sb.push_back(e);
      wr_before = wr_cnt;
      @(negedge Clk);
      // Scramble inputs after acceptance; the operation must not see them.
      OpA      = ~a;
      OpB      = ~b;
      DestAddr = ~dst;
      busy_cnt = 0;
      done_at  = 0;
      for (int k = 1; k <= 20; k++) begin
         if (k > 1) @(negedge Clk);
         Start = (k == p1) || (k == p2);
         if (Busy) busy_cnt++;
         if (Done && done_at == 0) done_at = k;
         if (!Busy) break;
      end
      Start = 1'b0;
      check("busy_cycles", busy_cnt, 10);
      check("done_cycle", done_at, 10);
      check("write_count", wr_cnt - wr_before, 2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      Reset    = 1'b1;
      Start    = 1'b0;
      OpA      = '0;
      OpB      = '0;
      DestAddr = '0;
      repeat (2) @(negedge Clk);
      check("rst_busy", int'(Busy), 0);
      check("rst_done", int'(Done), 0);
      check("rst_wren", int'(WrEn), 0);
      check("rst_wraddr", int'(WrAddr), 0);
      check("rst_wrdata", int'(WrData), 0);
      Reset = 1'b0;
      @(negedge Clk);

      run_op(8'h0F, 8'h11, 4'd3,  4'd3,  8'hFF, 4'd4, 8'h00, 0, 0);
      run_op(8'hFF, 8'hFF, 4'd6,  4'd6,  8'h01, 4'd7, 8'hFE, 0, 0);
      run_op(8'h80, 8'h02, 4'd15, 4'd15, 8'h00, 4'd0, 8'h01, 0, 0);
      run_op(8'h00, 8'hAA, 4'd5,  4'd5,  8'h00, 4'd6, 8'h00, 0, 0);
      // Start pulses at edges 3 and 10 of an active operation are ignored.
      run_op(8'hC8, 8'h64, 4'd1,  4'd1,  8'h20, 4'd2, 8'h4E, 3, 10);
      repeat (3) @(negedge Clk);
      check("no_spurious_busy", int'(Busy), 0);

      // Reset mid-CALC: outputs clear at once, no write or Done follows.
      Start    = 1'b1;
      OpA      = 8'h12;
      OpB      = 8'h34;
      DestAddr = 4'd2;
      @(negedge Clk);
      Start = 1'b0;
      for (int k = 2; k <= 5; k++) @(negedge Clk);
      check("pre_reset_busy", int'(Busy), 1);
      Reset = 1'b1;
      Start = 1'b1;
      #1;
      check("async_rst_busy", int'(Busy), 0);
      check("async_rst_wren", int'(WrEn), 0);
      check("async_rst_done", int'(Done), 0);
      check("async_rst_wrdata", int'(WrData), 0);
      @(negedge Clk);
      check("rst_start_ignored1", int'(Busy), 0);
      @(negedge Clk);
      check("rst_start_ignored2", int'(Busy), 0);
      Reset = 1'b0;
      Start = 1'b0;
      @(negedge Clk);
      check("post_rst_idle", int'(Busy), 0);
      run_op(8'h03, 8'h05, 4'd9,  4'd9,  8'h0F, 4'd10, 8'h00, 0, 0);

      repeat (4) @(negedge Clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule : tb_mul_seq
